// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage divide sequencer.
// Contents: FSM state encoding, the divide-by-zero quotient and the bit
// positions of the quotient/remainder fields in the divider result bus.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } div_state_e;

  // Quotient written for a zero divisor on the fast path (all ones).
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  // Divider result bus: {quotient, remainder}.
  localparam int QUOT_MSB = 63;
  localparam int QUOT_LSB = 32;
  localparam int REM_MSB  = 31;

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake bundle between the EX stage / shared divider and div_ctrl.
// Signals:
//   ex_div_req/ex_div_sign/ex_rs/ex_rt/ex_flush : request from EX
//   stall_req                                  : front-end stall
//   hilo_we/hi_wdata/lo_wdata                  : HI/LO write port
//   div_start/div_sign/div_a/div_b             : divider command
//   div_busy/div_done/div_result               : divider status/result
//   div_timeout                                : watchdog abort pulse
// Modports: slave = div_ctrl view, master = EX stage + divider view.
interface div_ctrl_if;
  logic        ex_div_req;
  logic        ex_div_sign;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_flush;
  logic        stall_req;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        div_start;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_busy;
  logic        div_done;
  logic [63:0] div_result;
  logic        div_timeout;

  modport slave (
    input  ex_div_req, ex_div_sign, ex_rs, ex_rt, ex_flush,
    input  div_busy, div_done, div_result,
    output stall_req, hilo_we, hi_wdata, lo_wdata,
    output div_start, div_sign, div_a, div_b, div_timeout
  );

  modport master (
    output ex_div_req, ex_div_sign, ex_rs, ex_rt, ex_flush,
    output div_busy, div_done, div_result,
    input  stall_req, hilo_we, hi_wdata, lo_wdata,
    input  div_start, div_sign, div_a, div_b, div_timeout
  );
endinterface

// File: rtl/div_ctrl.sv
// Execute-stage sequencer for the shared 32-bit divider (DIV/DIVU).
// Accepts a divide from EX, pulses div_start once, stalls the pipeline
// until the divider finishes, then writes quotient/remainder to HI/LO.
// Handles the zero-divisor fast path, flush while the divider is busy
// (the divider cannot be aborted, so its result is drained) and a
// watchdog that gives up after TIMEOUT cycles in WAIT.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : div_ctrl_if.slave (EX request, HI/LO write, divider handshake)
module div_ctrl
  import div_pkg::*;
#(
  parameter int TIMEOUT      = 64,
  parameter bit DIVZERO_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  div_ctrl_if.slave   bus
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'(TIMEOUT - 1);

  div_state_e       state_q, state_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic             op_sign_q, op_sign_d;
  logic [31:0]      res_quot_q, res_quot_d;
  logic [31:0]      res_rem_q, res_rem_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_pulse;
  logic             accept;

  assign accept = bus.ex_div_req && !bus.ex_flush;

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sign_q  <= 1'b0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
      wd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sign_q  <= op_sign_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_sign_d     = op_sign_q;
    res_quot_d    = res_quot_q;
    res_rem_d     = res_rem_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_pulse = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (DIVZERO_FAST && (bus.ex_rt == 32'd0)) begin
            // Zero divisor never reaches the divider.
            res_quot_d = DIV_ZERO_Q;
            res_rem_d  = bus.ex_rs;
            state_d    = S_DONE;
          end else begin
            op_a_d    = bus.ex_rs;
            op_b_d    = bus.ex_rt;
            op_sign_d = bus.ex_div_sign;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.div_done && bus.ex_flush) begin
          // Divider already finished, so nothing is left to drain.
          state_d = S_IDLE;
        end else if (bus.div_done) begin
          res_quot_d = bus.div_result[QUOT_MSB:QUOT_LSB];
          res_rem_d  = bus.div_result[REM_MSB:0];
          state_d    = S_DONE;
        end else if (bus.ex_flush) begin
          state_d = S_DRAIN;
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_pulse = 1'b1;
          state_d       = S_DRAIN;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.div_done || !bus.div_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---- outputs ----
  assign bus.div_start   = (state_q == S_ISSUE);
  assign bus.div_a       = op_a_q;
  assign bus.div_b       = op_b_q;
  assign bus.div_sign    = op_sign_q;
  assign bus.hilo_we     = (state_q == S_DONE) && !bus.ex_flush;
  assign bus.hi_wdata    = res_rem_q;
  assign bus.lo_wdata    = res_quot_q;
  assign bus.div_timeout = timeout_pulse;
  // Stall drops in DONE so EX advances on the edge HI/LO commits; in DRAIN
  // any new request is held off even if it arrives with a flush. Reset
  // forces it low so every output is quiet while rst is asserted.
  assign bus.stall_req   = !rst &&
                           ((accept && (state_q != S_DONE)) ||
                            ((state_q == S_DRAIN) && bus.ex_div_req));

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  import div_pkg::*;

  typedef struct {
    logic        sign;
    logic [31:0] rs;
    logic [31:0] rt;
    int          lat;
    logic [63:0] res;
    int          exp_start;
    int          exp_stall;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if dif();

  div_ctrl #(.TIMEOUT(64), .DIVZERO_FAST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Divider model controls (written only by the initial process)
  int          lat    = 20;
  logic [63:0] result = '0;
  bit          never  = 1'b0;
  bit          kill   = 1'b0;

  // Divider model state
  logic        busy_r;
  logic        done_r;
  int          cnt_r;

  assign dif.div_busy   = busy_r;
  assign dif.div_done   = done_r;
  assign dif.div_result = result;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r  <= 0;
    end else begin
      done_r <= 1'b0;
      if (kill) begin
        busy_r <= 1'b0;
        cnt_r  <= 0;
      end else if (dif.div_start) begin
        busy_r <= 1'b1;
        cnt_r  <= 1;
      end else if (busy_r) begin
        if (!never && cnt_r == lat) begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end else begin
          cnt_r <= cnt_r + 1;
        end
      end
    end
  end

  // Output monitor, sampled mid-cycle
  int          we_cnt    = 0;
  int          start_cnt = 0;
  int          to_cnt    = 0;
  logic [31:0] hi_seen   = '0;
  logic [31:0] lo_seen   = '0;
  logic [31:0] a_seen    = '0;
  logic [31:0] b_seen    = '0;
  logic        sign_seen = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (dif.hilo_we) begin
      we_cnt  <= we_cnt + 1;
      hi_seen <= dif.hi_wdata;
      lo_seen <= dif.lo_wdata;
    end
    if (dif.div_start) begin
      start_cnt <= start_cnt + 1;
      a_seen    <= dif.div_a;
      b_seen    <= dif.div_b;
      sign_seen <= dif.div_sign;
    end
    if (dif.div_timeout) to_cnt <= to_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_req(input logic req, input logic sign, input logic [31:0] rs,
                           input logic [31:0] rt);
    dif.ex_div_req  = req;
    dif.ex_div_sign = sign;
    dif.ex_rs       = rs;
    dif.ex_rt       = rt;
  endtask

  task automatic wait_start(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (dif.div_start) begin seen = 1'b1; break; end
    end
    chk({tag, "_start_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int we0, st0, stall_n;
    bit fin;
    we0 = we_cnt; st0 = start_cnt;
    lat = v.lat; result = v.res;
    @(negedge clk);
    dif.ex_flush = 1'b0;
    drive_req(1'b1, v.sign, v.rs, v.rt);
    #1;
    stall_n = 0; fin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!dif.stall_req) begin fin = 1'b1; break; end
      stall_n++;
      @(negedge clk); #1;
    end
    chk({tag, "_finished"}, 64'(fin), 64'd1);
    @(posedge clk); #1;
    dif.ex_div_req = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk({tag, "_hilo_we_count"}, 64'(we_cnt - we0), 64'd1);
    chk({tag, "_start_count"}, 64'(start_cnt - st0), 64'(v.exp_start));
    chk({tag, "_stall_cycles"}, 64'(stall_n), 64'(v.exp_stall));
    chk({tag, "_hi"}, 64'(hi_seen), 64'(v.exp_hi));
    chk({tag, "_lo"}, 64'(lo_seen), 64'(v.exp_lo));
    if (v.exp_start != 0) begin
      chk({tag, "_div_a"}, 64'(a_seen), 64'(v.rs));
      chk({tag, "_div_b"}, 64'(b_seen), 64'(v.rt));
      chk({tag, "_div_sign"}, 64'(sign_seen), 64'(v.sign));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t vecs[5];
    vec_t vr;
    int we0, st0, to0, k, stall_hi;
    bit seen;

    vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 20, {32'hFFFF_FFFD, 32'hFFFF_FFFF},
                1, 23, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[1] = '{1'b0, 32'd100, 32'd0, 20, 64'd0, 0, 1, 32'd100, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 32'd10, 32'd3, 5, {32'd3, 32'd1}, 1, 8, 32'd1, 32'd3};
    vecs[3] = '{1'b1, 32'hFFFF_FFFB, 32'd0, 5, 64'd0, 0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2, {32'h8000_0000, 32'd0},
                1, 5, 32'd0, 32'h8000_0000};

    dif.ex_flush = 1'b0;
    drive_req(1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 64'(dif.stall_req), 64'd0);
    chk("rst_we_start_to", 64'({dif.hilo_we, dif.div_start, dif.div_timeout}), 64'd0);
    chk("rst_hi_lo", {dif.hi_wdata, dif.lo_wdata}, 64'd0);
    chk("rst_div_ab", {dif.div_a, dif.div_b}, 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(S_IDLE));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Flush during WAIT, new request held through DRAIN
    we0 = we_cnt; st0 = start_cnt;
    lat = 30; result = {32'd4, 32'd1};
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'd10, 32'd3);
    wait_start("flush");
    repeat (5) @(negedge clk);
    dif.ex_flush = 1'b1;
    @(negedge clk);
    dif.ex_flush = 1'b0;
    drive_req(1'b1, 1'b0, 32'd9, 32'd2);
    #1;
    chk("flush_state_drain", 64'(dut.state_q), 64'(S_DRAIN));
    stall_hi = 0;
    for (int i = 0; i < 3; i++) begin
      if (dif.stall_req) stall_hi++;
      @(negedge clk); #1;
    end
    chk("flush_drain_stall", 64'(stall_hi), 64'd3);
    chk("flush_no_early_we", 64'(we_cnt - we0), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!dif.stall_req) begin seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("flush_second_finished", 64'(seen), 64'd1);
    @(posedge clk); #1;
    dif.ex_div_req = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("flush_we_count", 64'(we_cnt - we0), 64'd1);
    chk("flush_start_count", 64'(start_cnt - st0), 64'd2);
    chk("flush_hi", 64'(hi_seen), 64'd1);
    chk("flush_lo", 64'(lo_seen), 64'd4);
    chk("flush_div_ab", {a_seen, b_seen}, {32'd9, 32'd2});

    // div_done and ex_flush in the same cycle
    we0 = we_cnt;
    lat = 4; result = {32'd4, 32'd0};
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'd20, 32'd5);
    wait_start("df");
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (dif.div_done) begin seen = 1'b1; break; end
    end
    chk("df_done_seen", 64'(seen), 64'd1);
    dif.ex_flush = 1'b1;
    #1;
    chk("df_stall", 64'(dif.stall_req), 64'd0);
    @(posedge clk); #1;
    dif.ex_flush = 1'b0;
    dif.ex_div_req = 1'b0;
    @(negedge clk); #1;
    chk("df_state_idle", 64'(dut.state_q), 64'(S_IDLE));
    repeat (3) @(negedge clk);
    #3;
    chk("df_no_we", 64'(we_cnt - we0), 64'd0);

    // Watchdog: divider never completes
    we0 = we_cnt; to0 = to_cnt;
    never = 1'b1;
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'd7, 32'd1);
    wait_start("wd");
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk); #1;
      if (dif.div_timeout) begin k = i; break; end
    end
    chk("wd_timeout_cycle", 64'(k), 64'd64);
    @(posedge clk); #1;
    dif.ex_div_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("wd_state_drain", 64'(dut.state_q), 64'(S_DRAIN));
    kill = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    kill = 1'b0;
    never = 1'b0;
    chk("wd_state_idle", 64'(dut.state_q), 64'(S_IDLE));
    chk("wd_timeout_count", 64'(to_cnt - to0), 64'd1);
    chk("wd_no_we", 64'(we_cnt - we0), 64'd0);

    // Asynchronous reset in the middle of WAIT
    lat = 20; result = {32'd7, 32'd1};
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'd50, 32'd7);
    wait_start("ar");
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_stall", 64'(dif.stall_req), 64'd0);
    chk("ar_div_ab", {dif.div_a, dif.div_b}, 64'd0);
    chk("ar_ctrl_outs", 64'({dif.hilo_we, dif.div_start, dif.div_sign, dif.div_timeout}), 64'd0);
    chk("ar_hi_lo", {dif.hi_wdata, dif.lo_wdata}, 64'd0);
    chk("ar_state", 64'(dut.state_q), 64'(S_IDLE));
    @(negedge clk);
    dif.ex_div_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vr = '{1'b0, 32'd50, 32'd7, 3, {32'd7, 32'd1}, 1, 6, 32'd1, 32'd7};
    run_txn(vr, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Execute-stage sequencer for the shared 32-bit divider unit (DIV/DIVU). It accepts a divide request from the EX stage and issues a one-cycle start to the divider. It holds a pipeline stall until the divider reports completion, then writes quotient and remainder to HI/LO. It also owns the divide-by-zero fast path, flush/cancel while the divider is busy (the divider cannot be aborted), and a watchdog.

Parameters:
TIMEOUT, 64, max cycles in WAIT before abort; counter width = clog2(TIMEOUT+1)
DIVZERO_FAST, 1, 1 = B==0 bypasses the divider with a fixed result

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ex_div_req  in  1  EX holds a DIV/DIVU; held stable while stall_req=1
ex_div_sign  in  1  1 = DIV (signed), 0 = DIVU
ex_rs  in  32  dividend
ex_rt  in  32  divisor
ex_flush  in  1  squash current EX instruction
stall_req  out  1  stall the front of the pipeline
hilo_we  out  1  HI/LO write strobe, 1 cycle
hi_wdata  out  32  remainder
lo_wdata  out  32  quotient
div_start  out  1  start pulse to divider (its sourceData)
div_sign  out  1  signed select to divider
div_a  out  32  dividend to divider
div_b  out  32  divisor to divider
div_busy  in  1  divider hasData
div_done  in  1  divider dataOK, 1-cycle pulse
div_result  in  64  [63:32] quotient, [31:0] remainder
div_timeout  out  1  1-cycle pulse on watchdog abort

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, DRAIN. Registers: op_a, op_b, op_sign, res_q, res_r, wd_cnt.
- Reset (async, any state): state=IDLE. All outputs 0. Operand/result registers 0. wd_cnt=0.
- IDLE:
  - ex_div_req & !ex_flush & (DIVZERO_FAST & ex_rt==0): res_q=32'hFFFF_FFFF, res_r=ex_rs, go to DONE. Divider untouched.
  - ex_div_req & !ex_flush, otherwise: latch operands and sign, go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle. div_a/div_b/div_sign come from the registers and stay stable until IDLE. wd_cnt cleared. Go to WAIT.
- WAIT:
  - div_done: capture res_q=div_result[63:32], res_r=div_result[31:0]; go to DONE.
  - Else ex_flush: go to DRAIN.
  - Else wd_cnt==TIMEOUT-1: pulse div_timeout, go to DRAIN.
  - Else wd_cnt++.
  - div_done and ex_flush in the same cycle: flush wins; result discarded; go to IDLE directly.
- DONE: hilo_we=1 for one cycle with hi_wdata=res_r, lo_wdata=res_q, unless ex_flush is high this cycle, in which case hilo_we=0. Then IDLE.
- DRAIN: wait for div_done (or div_busy==0), discard the result, then IDLE. New requests are not accepted here.
- stall_req (combinational):
  - ex_div_req & !ex_flush & state!=DONE; or
  - state==DRAIN & ex_div_req.
  - It drops in DONE so the pipeline advances on the same edge hilo_we commits.
- Latency: req accepted at edge T, div_start high in T+1, hilo_we one cycle after div_done. Fast path: hilo_we at T+1.
- Back-to-back: the next request is accepted in IDLE the cycle after DONE, so there is at least one bubble between divides.
- hi_wdata/lo_wdata are held between writes; outside hilo_we they are don't-care.
- Sign handling (signed vs unsigned results) is entirely the divider's job. This block never alters results except on the fast path.

Decomposition:
- Shared package div_pkg: state encoding (3-bit enum), DIV_ZERO_Q = 32'hFFFF_FFFF, result-field bit positions (QUOT_MSB=63, QUOT_LSB=32, REM_MSB=31).
- No sub-module. Single FSM plus the watchdog counter. The divider is instantiated alongside this block in the execute stage, not inside it.

Test Plan:
- DIV ex_rs=-7 (0xFFFFFFF9), ex_rt=2; model div_done 20 cycles after start with result {0xFFFFFFFD, 0xFFFFFFFF} -> div_start exactly one pulse, stall_req high until DONE, hilo_we once with HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIVU ex_rs=100, ex_rt=0, DIVZERO_FAST=1 -> no div_start; hilo_we one cycle after acceptance with HI=100, LO=0xFFFFFFFF; stall_req high for exactly 1 cycle.
- DIVU 10/3 accepted, ex_flush 5 cycles into WAIT, then new req 9/2 presented -> enter DRAIN; stall_req held; no hilo_we for 10/3. After div_done, 9/2 issues and writes HI=1, LO=4.
- div_done and ex_flush in the same cycle -> no hilo_we; state back to IDLE the next cycle.
- Model divider never asserts div_done, TIMEOUT=64 -> div_timeout pulses on cycle 64 of WAIT; DRAIN until div_busy=0; no hilo_we.
- Assert rst mid-WAIT -> all outputs 0 immediately (asynchronous); state=IDLE; a subsequent request completes normally.
